// File: rtl/apmon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apmon_pkg
// Description : Shared types, read-select codes and the saturating increment
//               helper for the ap_ctrl handshake performance monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package apmon_pkg;

    // Per-channel handshake tracking state
    typedef enum logic [1:0] {
        APMON_IDLE      = 2'd0,
        APMON_RUN       = 2'd1,
        APMON_WAIT_CONT = 2'd2
    } apmon_state_e;

    // Statistic select codes for the indexed read port
    localparam logic [2:0] APMON_SEL_TXN   = 3'd0;
    localparam logic [2:0] APMON_SEL_LAST  = 3'd1;
    localparam logic [2:0] APMON_SEL_MIN   = 3'd2;
    localparam logic [2:0] APMON_SEL_MAX   = 3'd3;
    localparam logic [2:0] APMON_SEL_INT   = 3'd4;
    localparam logic [2:0] APMON_SEL_STALL = 3'd5;
    localparam logic [2:0] APMON_SEL_STAT  = 3'd6;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    // Operates on a 64-bit container so callers of any counter width share it.
    function automatic logic [63:0] apmon_sat_inc(input logic [63:0] val, input int width);
        logic [63:0] top;
        top = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (val >= top) ? top : (val + 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apmon_channel.sv
`default_nettype none
// ============================================================================
// Module      : apmon_channel
// Description : One monitored HLS instance: handshake FSM, latency/interval/
//               stall counters and min/max tracking. Stall counting is only
//               built when APMON_STALL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module apmon_channel
    import apmon_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             finish,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] last_lat,
    output logic [CNT_W-1:0] min_lat,
    output logic [CNT_W-1:0] max_lat,
    output logic [CNT_W-1:0] last_int,
    output logic [CNT_W-1:0] stall_cnt,
    output apmon_state_e     state,
    output logic             busy,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

    apmon_state_e     next_state;
    logic             capture;
    logic             lat_load;
    logic             lat_step;
    logic             stall_step;
    logic             stall_ovf;
    logic             int_step;
    logic [CNT_W-1:0] cap_val;
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] int_cnt;
    logic             int_armed;

    function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] v);
        return CNT_W'(apmon_sat_inc(64'(v), CNT_W));
    endfunction

    // State register; clear returns the FSM to IDLE like reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= APMON_IDLE;
        end else if (clear) begin
            state <= APMON_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; finish freezes the FSM
    always_comb begin
        next_state = state;
        if (!finish) begin
            case (state)
                APMON_IDLE: begin
                    // A start with done in the same cycle is a combinational
                    // module: the start is consumed by that transaction.
                    if (ap_start) begin
                        if (ap_done) begin
                            next_state = ap_continue ? APMON_IDLE : APMON_WAIT_CONT;
                        end else begin
                            next_state = APMON_RUN;
                        end
                    end
                end
                APMON_RUN: begin
                    if (ap_done) begin
                        if (!ap_continue) begin
                            next_state = APMON_WAIT_CONT;
                        end else if (ap_start) begin
                            next_state = APMON_RUN;
                        end else begin
                            next_state = APMON_IDLE;
                        end
                    end
                end
                APMON_WAIT_CONT: begin
                    if (ap_continue) begin
                        next_state = APMON_IDLE;
                    end
                end
                default: next_state = APMON_IDLE;
            endcase
        end
    end

    // Per-state counter strobes and the latency value to record
    always_comb begin
        capture    = 1'b0;
        lat_load   = 1'b0;
        lat_step   = 1'b0;
        stall_step = 1'b0;
        cap_val    = '0;
        if (!finish) begin
            case (state)
                APMON_IDLE: begin
                    if (ap_start) begin
                        capture  = ap_done;
                        lat_load = !ap_done;
                    end
                end
                APMON_RUN: begin
                    if (ap_done) begin
                        capture  = 1'b1;
                        cap_val  = lat_cnt;
                        lat_load = ap_continue && ap_start;
                    end else begin
                        lat_step = 1'b1;
                    end
                end
                APMON_WAIT_CONT: stall_step = 1'b1;
                default: ;
            endcase
        end
        busy = (state != APMON_IDLE);
    end

    assign int_step = !finish && int_armed && !ap_ready;

    // Running latency counter of the transaction in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_cnt <= '0;
        end else if (clear) begin
            lat_cnt <= '0;
        end else if (lat_load) begin
            lat_cnt <= ONE;
        end else if (lat_step) begin
            lat_cnt <= sat_step(lat_cnt);
        end
    end

    // Completed-transaction statistics
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            txn_cnt  <= '0;
            last_lat <= '0;
            min_lat  <= ALL_ONES;
            max_lat  <= '0;
        end else if (clear) begin
            txn_cnt  <= '0;
            last_lat <= '0;
            min_lat  <= ALL_ONES;
            max_lat  <= '0;
        end else if (capture) begin
            txn_cnt  <= sat_step(txn_cnt);
            last_lat <= cap_val;
            if (cap_val < min_lat) begin
                min_lat <= cap_val;
            end
            if (cap_val > max_lat) begin
                max_lat <= cap_val;
            end
        end
    end

    // Ready-to-ready interval; the first ready only arms the counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            int_cnt   <= '0;
            int_armed <= 1'b0;
            last_int  <= '0;
        end else if (clear) begin
            int_cnt   <= '0;
            int_armed <= 1'b0;
            last_int  <= '0;
        end else if (!finish) begin
            if (ap_ready) begin
                if (int_armed) begin
                    last_int <= int_cnt;
                end
                int_cnt   <= ONE;
                int_armed <= 1'b1;
            end else if (int_armed) begin
                int_cnt <= sat_step(int_cnt);
            end
        end
    end

`ifdef APMON_STALL_EN
    // Cycles spent waiting for ap_continue after done
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (clear) begin
            stall_cnt <= '0;
        end else if (stall_step) begin
            stall_cnt <= sat_step(stall_cnt);
        end
    end
`else
    assign stall_cnt = '0;
`endif

    // With stall counting absent stall_cnt is constant zero, so this folds away
    assign stall_ovf = stall_step && (&stall_cnt);

    // Sticky flag: any counter asked to step past all-ones
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (clear) begin
            ovf <= 1'b0;
        end else if ((lat_step && (&lat_cnt)) || (capture && (&txn_cnt)) ||
                     (int_step && (&int_cnt)) || stall_ovf) begin
            ovf <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ap_ctrl_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ap_ctrl_perf_monitor
// Description : Parallel ap_ctrl_hs/ap_ctrl_chain performance monitor for
//               NUM_CH HLS instances with a registered indexed read port.
//               Define APMON_STALL_EN to include continue-stall counting.
// Revision    : 1.0 - initial release
// ============================================================================
module ap_ctrl_perf_monitor
    import apmon_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 32,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              finish,
    input  logic              clear,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] ovf
);

    logic [CNT_W-1:0] ch_word [NUM_CH];
    logic [CNT_W-1:0] sel_word;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] txn_cnt;
        logic [CNT_W-1:0] last_lat;
        logic [CNT_W-1:0] min_lat;
        logic [CNT_W-1:0] max_lat;
        logic [CNT_W-1:0] last_int;
        logic [CNT_W-1:0] stall_cnt;
        apmon_state_e     state;
        logic [CNT_W-1:0] word;

        apmon_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clock       (clock),
            .reset       (reset),
            .clear       (clear),
            .finish      (finish),
            .ap_start    (ap_start[c]),
            .ap_ready    (ap_ready[c]),
            .ap_done     (ap_done[c]),
            .ap_continue (ap_continue[c]),
            .txn_cnt     (txn_cnt),
            .last_lat    (last_lat),
            .min_lat     (min_lat),
            .max_lat     (max_lat),
            .last_int    (last_int),
            .stall_cnt   (stall_cnt),
            .state       (state),
            .busy        (busy[c]),
            .ovf         (ovf[c])
        );

        // Statistic select for this channel
        always_comb begin
            word = '0;
            case (rd_sel)
                APMON_SEL_TXN:   word = txn_cnt;
                APMON_SEL_LAST:  word = last_lat;
                APMON_SEL_MIN:   word = min_lat;
                APMON_SEL_MAX:   word = max_lat;
                APMON_SEL_INT:   word = last_int;
                APMON_SEL_STALL: word = stall_cnt;
                APMON_SEL_STAT:  word = CNT_W'({state, ovf[c]});
                default:         word = '0;
            endcase
        end

        assign ch_word[c] = word;
    end

    // Channel select; indices past NUM_CH match nothing and read zero
    always_comb begin
        sel_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if ({1'b0, rd_ch} == (CH_W + 1)'(c)) begin
                sel_word = ch_word[c];
            end
        end
    end

    // Registered read port; data holds between strobes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= sel_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ap_ctrl_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ap_ctrl_perf_monitor
// Description : Self-checking bench: directed handshake scenarios with literal
//               expectations, then randomized traffic against a cycle-count
//               based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ap_ctrl_perf_monitor;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 4;
    localparam int CH_W   = 2;
    localparam int MAXV   = 15;

    localparam logic [2:0] S_TXN = 3'd0, S_LAST = 3'd1, S_MIN = 3'd2, S_MAX = 3'd3,
                           S_INT = 3'd4, S_STALL = 3'd5, S_STAT = 3'd6;

`ifdef APMON_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_CH-1:0] ap_start = '0;
    logic [NUM_CH-1:0] ap_ready = '0;
    logic [NUM_CH-1:0] ap_done = '0;
    logic [NUM_CH-1:0] ap_continue = '1;
    logic              finish = 1'b0;
    logic              clear = 1'b0;
    logic              rd_en = 1'b0;
    logic [CH_W-1:0]   rd_ch = '0;
    logic [2:0]        rd_sel = '0;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_valid;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] ovf;

    always #5 clock = ~clock;

    ap_ctrl_perf_monitor #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_continue (ap_continue),
        .finish      (finish),
        .clear       (clear),
        .rd_en       (rd_en),
        .rd_ch       (rd_ch),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .ovf         (ovf)
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    // ---------------- reference model (true counts, saturated on report) -----
    int     m_st    [NUM_CH];   // 0 idle, 1 running, 2 waiting for continue
    longint m_sc    [NUM_CH];   // active-cycle index of the current start
    longint m_txn   [NUM_CH];
    int     m_last  [NUM_CH];
    int     m_min   [NUM_CH];
    int     m_max   [NUM_CH];
    int     m_int   [NUM_CH];
    longint m_rc    [NUM_CH];   // active-cycle index of the previous ready
    bit     m_armed [NUM_CH];
    longint m_stall [NUM_CH];
    bit     m_ovf   [NUM_CH];
    longint m_cyc;              // edges where the monitor was not frozen
    int     exp_rd;
    bit     exp_valid;

    function automatic int sat(input longint v);
        return (v > MAXV) ? MAXV : int'(v);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_st[c] = 0; m_sc[c] = 0; m_txn[c] = 0; m_last[c] = 0;
            m_min[c] = MAXV; m_max[c] = 0; m_int[c] = 0; m_rc[c] = 0;
            m_armed[c] = 1'b0; m_stall[c] = 0; m_ovf[c] = 1'b0;
        end
        m_cyc = 0;
    endtask

    task automatic model_record(input int c, input longint lat);
        m_last[c] = sat(lat);
        if (m_txn[c] >= MAXV) m_ovf[c] = 1'b1;
        m_txn[c]++;
        if (m_last[c] < m_min[c]) m_min[c] = m_last[c];
        if (m_last[c] > m_max[c]) m_max[c] = m_last[c];
    endtask

    function automatic int model_read(input int c, input int sel);
        if (c >= NUM_CH) return 0;
        case (sel)
            0: return sat(m_txn[c]);
            1: return m_last[c];
            2: return m_min[c];
            3: return m_max[c];
            4: return m_int[c];
            5: return STALL_EN ? sat(m_stall[c]) : 0;
            6: return m_st[c] * 2 + int'(m_ovf[c]);
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            if (ap_ready[c]) begin
                if (m_armed[c]) m_int[c] = sat(m_cyc - m_rc[c]);
                m_rc[c] = m_cyc;
                m_armed[c] = 1'b1;
            end else if (m_armed[c] && (m_cyc - m_rc[c] >= MAXV)) begin
                m_ovf[c] = 1'b1;
            end
            case (m_st[c])
                0: begin
                    if (ap_start[c] && ap_done[c]) begin
                        model_record(c, 0);
                        m_st[c] = ap_continue[c] ? 0 : 2;
                    end else if (ap_start[c]) begin
                        m_st[c] = 1;
                        m_sc[c] = m_cyc;
                    end
                end
                1: begin
                    if (ap_done[c]) begin
                        model_record(c, m_cyc - m_sc[c]);
                        if (!ap_continue[c]) m_st[c] = 2;
                        else if (ap_start[c]) m_sc[c] = m_cyc;
                        else m_st[c] = 0;
                    end else if (m_cyc - m_sc[c] >= MAXV) begin
                        m_ovf[c] = 1'b1;
                    end
                end
                default: begin
                    if (STALL_EN) begin
                        if (m_stall[c] >= MAXV) m_ovf[c] = 1'b1;
                        m_stall[c]++;
                    end
                    if (ap_continue[c]) m_st[c] = 0;
                end
            endcase
        end
        m_cyc++;
    endtask

    // Model advances on every edge the DUT sees; reads use pre-update state
    initial begin
        model_reset();
        exp_rd = 0;
        exp_valid = 1'b0;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                model_reset();
                exp_rd = 0;
                exp_valid = 1'b0;
            end else begin
                if (rd_en) exp_rd = model_read(int'(rd_ch), int'(rd_sel));
                exp_valid = rd_en;
                if (clear) model_reset();
                else if (!finish) model_step();
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Continuous comparison on the falling edge
    initial begin
        forever begin
            @(negedge clock);
            if (chk_on) begin
                logic [NUM_CH-1:0] eb;
                logic [NUM_CH-1:0] eo;
                for (int c = 0; c < NUM_CH; c++) begin
                    eb[c] = (m_st[c] != 0);
                    eo[c] = m_ovf[c];
                end
                check("rd_valid", 32'(rd_valid), 32'(exp_valid));
                check("rd_data", 32'(rd_data), 32'(exp_rd));
                check("busy", 32'(busy), 32'(eb));
                check("ovf", 32'(ovf), 32'(eo));
            end
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd_chk(input int ch, input logic [2:0] sel, input int expv, input string name);
        rd_en = 1'b1;
        rd_ch = CH_W'(ch);
        rd_sel = sel;
        tick();
        check(name, 32'(rd_data), 32'(expv));
        check({name, "_valid"}, 32'(rd_valid), 32'd1);
        rd_en = 1'b0;
    endtask

    // Start, wait lat cycles, done; continue low for 'low' cycles from done
    task automatic run_txn(input int ch, input int lat, input int low);
        ap_start[ch] = 1'b1;
        tick();
        ap_start[ch] = 1'b0;
        repeat (lat - 1) tick();
        ap_done[ch] = 1'b1;
        ap_continue[ch] = (low == 0);
        tick();
        ap_done[ch] = 1'b0;
        if (low > 0) begin
            repeat (low - 1) tick();
            ap_continue[ch] = 1'b1;
            tick();
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk_on = 1'b1;

        // Reset state
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rd_chk(0, S_MIN, 15, "rst_min");
        rd_chk(1, S_TXN, 0, "rst_txn");
        tick(); tick();

        // Single transaction, latency 7
        run_txn(0, 7, 0);
        check("busy_after_done", 32'(busy[0]), 32'd0);
        rd_chk(0, S_TXN, 1, "lat_txn");
        rd_chk(0, S_LAST, 7, "lat_last");
        rd_chk(0, S_MIN, 7, "lat_min");
        rd_chk(0, S_MAX, 7, "lat_max");

        // Latency range 5, 9, 3
        run_txn(1, 5, 0);
        run_txn(1, 9, 0);
        run_txn(1, 3, 0);
        rd_chk(1, S_MIN, 3, "rng_min");
        rd_chk(1, S_MAX, 9, "rng_max");
        rd_chk(1, S_LAST, 3, "rng_last");
        rd_chk(1, S_TXN, 3, "rng_txn");

        // Continue held low for 4 cycles
        run_txn(2, 2, 4);
        rd_chk(2, S_STALL, STALL_EN ? 4 : 0, "stall");

        // Back-to-back: done+continue+start keeps RUN, relatch from 1
        ap_start[0] = 1'b1;
        tick();
        ap_start[0] = 1'b0;
        tick(); tick();
        ap_done[0] = 1'b1;
        ap_start[0] = 1'b1;
        tick();
        ap_done[0] = 1'b0;
        ap_start[0] = 1'b0;
        check("b2b_busy", 32'(busy[0]), 32'd1);
        rd_chk(0, S_STAT, 2, "b2b_state");
        tick(); tick();
        ap_done[0] = 1'b1;
        tick();
        ap_done[0] = 1'b0;
        rd_chk(0, S_LAST, 4, "b2b_last");
        rd_chk(0, S_TXN, 3, "b2b_txn");

        // Combinational module: start and done together
        ap_start[1] = 1'b1;
        ap_done[1] = 1'b1;
        tick();
        ap_start[1] = 1'b0;
        ap_done[1] = 1'b0;
        rd_chk(1, S_LAST, 0, "comb_last");
        rd_chk(1, S_MIN, 0, "comb_min");
        rd_chk(1, S_TXN, 4, "comb_txn");

        // Ready at relative cycles 0, 6, 9
        ap_ready[2] = 1'b1; tick(); ap_ready[2] = 1'b0;
        repeat (5) tick();
        ap_ready[2] = 1'b1; tick(); ap_ready[2] = 1'b0;
        repeat (2) tick();
        ap_ready[2] = 1'b1; tick(); ap_ready[2] = 1'b0;
        rd_chk(2, S_INT, 3, "interval");

        // Saturation with a 20-cycle run
        run_txn(0, 20, 0);
        rd_chk(0, S_LAST, 15, "sat_last");
        rd_chk(0, S_STAT, 1, "sat_stat");
        check("sat_ovf", 32'(ovf[0]), 32'd1);
        rd_chk(3, S_TXN, 0, "oob_ch");

        // Clear mid-run
        ap_start[1] = 1'b1; tick(); ap_start[1] = 1'b0;
        tick(); tick();
        clear = 1'b1; tick(); clear = 1'b0;
        check("clr_busy", 32'(busy), 32'd0);
        rd_chk(1, S_TXN, 0, "clr_txn");
        rd_chk(1, S_MIN, 15, "clr_min");
        rd_chk(0, S_STAT, 0, "clr_stat");

        // Finish freezes state and statistics
        run_txn(2, 3, 0);
        ap_start[2] = 1'b1; tick(); ap_start[2] = 1'b0;
        tick();
        finish = 1'b1;
        ap_done[2] = 1'b1;
        repeat (4) tick();
        ap_done[2] = 1'b0;
        rd_chk(2, S_TXN, 1, "fin_txn");
        rd_chk(2, S_STAT, 2, "fin_state");
        finish = 1'b0;
        tick();
        ap_done[2] = 1'b1; tick(); ap_done[2] = 1'b0;
        rd_chk(2, S_LAST, 3, "fin_last");
        rd_chk(2, S_TXN, 2, "fin_txn2");

        // Asynchronous reset mid-run
        ap_start[0] = 1'b1; tick(); ap_start[0] = 1'b0;
        tick();
        #3 reset = 1'b1;
        #1 check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(rd_valid), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        rd_chk(0, S_TXN, 0, "arst_txn");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ap_start[c]    = ($urandom_range(0, 9) < 3);
                ap_done[c]     = ($urandom_range(0, 9) < 2);
                ap_ready[c]    = ($urandom_range(0, 9) < 2);
                ap_continue[c] = ($urandom_range(0, 9) < 7);
            end
            finish = ($urandom_range(0, 19) == 0);
            clear  = ($urandom_range(0, 199) == 0);
            rd_en  = $urandom_range(0, 1) == 1;
            rd_ch  = CH_W'($urandom_range(0, 3));
            rd_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 599) == 0) begin
                #3 reset = 1'b1;
                @(posedge clock);
                #1 reset = 1'b0;
            end else begin
                tick();
            end
        end
        ap_start = '0;
        ap_done = '0;
        rd_en = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ap_ctrl_perf_monitor.md
# ap_ctrl_perf_monitor

Synthesizable, parametrised successor to the single-module dataflow status dumper. Monitors `ap_ctrl_hs`/`ap_ctrl_chain` handshakes (`ap_start`/`ap_ready`/`ap_done`/`ap_continue`) on NUM_CH HLS module instances in parallel. Per channel it keeps transaction count, start-to-done latency (last/min/max), ready-to-ready interval and continue-stall cycles. Results are read through a registered indexed read port, so it works in silicon and in cosim without a CSV dump.

## Interface
- NUM_CH, 4: number of monitored module instances (1..16).
- CNT_W, 32: width of every counter and of `rd_data`.
- `clock` in 1: sole clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `ap_start` in NUM_CH: per-channel start, sampled.
- `ap_ready` in NUM_CH: per-channel ready.
- `ap_done` in NUM_CH: per-channel done.
- `ap_continue` in NUM_CH: per-channel continue; tie 1 for `ap_ctrl_hs`.
- `finish` in 1: end of simulation/run; freezes all statistics while high.
- `clear` in 1: synchronous clear of all statistics, same values as reset.
- `rd_en` in 1: read strobe.
- `rd_ch` in $clog2(NUM_CH) (min 1): channel to read.
- `rd_sel` in 3: statistic select, see Operation.
- `rd_data` out CNT_W: read result; reset 0.
- `rd_valid` out 1: `rd_data` valid; reset 0.
- `busy` out NUM_CH: channel FSM not IDLE; reset 0.
- `ovf` out NUM_CH: sticky saturation flag; reset 0.

## Operation
- Per-channel FSM has three states: IDLE, RUN, WAIT_CONT.
  - IDLE → RUN: `ap_start`=1 and `ap_done`=0. Latency counter loads 1.
  - RUN: latency counter +1 per cycle. On `ap_done`=1 the counter value is captured as the latency; `txn_cnt`+1; min and max are updated.
  - Done with `ap_continue`=1: go to IDLE, or stay in RUN with counter reloaded to 1 if `ap_start`=1 in the same cycle (back-to-back).
  - Done with `ap_continue`=0: go to WAIT_CONT.
  - IDLE with `ap_start`=`ap_done`=1 (combinational module): latency 0 is recorded and counted. Next state follows the same `ap_continue` rule.
  - WAIT_CONT: `stall_cnt`+1 per cycle; `ap_continue`=1 → IDLE.
- Interval: counts cycles since the previous `ap_ready`=1 cycle. Each `ap_ready` after the first captures `last_int`. The first `ap_ready` after reset or `clear` only arms the counter.
- Counter saturation: every counter saturates at all-ones and sets `ovf[ch]`. A saturated latency is still recorded as all-ones.
- Reset/`clear` values: all counters 0, `min_lat` all-ones, FSMs IDLE.
  - Reset mid-transaction abandons the transaction; nothing is counted.
  - `clear` has priority over every update in the same cycle.
- `finish`=1: FSMs and counters hold their values. The read port still works.
- `rd_sel` encoding:
  - 0: `txn_cnt`
  - 1: `last_lat`
  - 2: `min_lat`
  - 3: `max_lat`
  - 4: `last_int`
  - 5: `stall_cnt`
  - 6: {state, `ovf`} zero-extended
  - 7: 0
- Out-of-range `rd_ch` returns 0.

## Timing
- Handshake inputs are sampled on the rising edge; statistics update on the same edge.
- Stats are readable the cycle after the done edge.
- Read latency is 1 cycle: `rd_valid` is `rd_en` delayed by one cycle, and `rd_data` is registered with it.
- `rd_data` holds its value while `rd_en`=0.
- Reading and updating the same statistic in the same cycle returns the pre-update value.
- The monitor never drives the monitored handshake.

## Configuration
- `APMON_STALL_EN` defined: WAIT_CONT stall counting is present.
- `APMON_STALL_EN` undefined:
  - `stall_cnt` logic is removed and `rd_sel`=5 reads 0.
  - The FSM still honours `ap_continue`.

## Structure
- `apmon_pkg` holds:
  - the state enum `apmon_state_e`;
  - `rd_sel` localparams `APMON_SEL_TXN` … `APMON_SEL_STAT`;
  - the saturating-increment function.
- Sub-module `apmon_channel` holds one FSM plus its counters and is generated NUM_CH times.
- The top level holds the generate loop, the read mux and the output registers.

## Test plan
- Latency: start at cycle 10, done at cycle 17 (`ap_continue`=1) → `txn_cnt`=1, `last_lat`=`min_lat`=`max_lat`=7, `busy` low at 18.
- Latency range: three transactions with latencies 5, 9, 3 → `min_lat`=3, `max_lat`=9, `last_lat`=3, `txn_cnt`=3.
- Continue stall: done with `ap_continue` held low 4 cycles → `stall_cnt`=4 (0 when `APMON_STALL_EN` is undefined).
- Back-to-back and combinational: done+continue+start in one cycle → state stays RUN and the next latency is measured from 1. Start+done together in IDLE → latency 0 counted.
- Interval and overflow:
  - `ap_ready` pulses at cycles 20, 26, 29 → `last_int`=3.
  - With CNT_W=4, a 20-cycle run → `last_lat`=15, `ovf`=1.
- Control: `clear` mid-run, async `reset` mid-run and `finish` freeze → all stats at reset values / frozen. Each `rd_en` gives `rd_valid` exactly one cycle later.
